// File: rtl/wash_cycle_sequencer.sv
// Phase sequencer for the washing-machine controller: fill, wash, rinse, optional
// second wash+rinse, spin. Each phase is timed against the duration returned by the external ROM.
module wash_cycle_sequencer #(
  parameter int         CNT_W      = 32,
  parameter logic [2:0] FILL_CODE  = 3'b001,
  parameter logic [2:0] WASH_CODE  = 3'b011,
  parameter logic [2:0] RINSE_CODE = 3'b111,
  parameter logic [2:0] SPIN_CODE  = 3'b110,
  parameter logic [2:0] IDLE_CODE  = 3'b000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_in,
  input  logic             double_wash,
  input  logic [1:0]       clk_freq,
  input  logic             timer_pause,
  input  logic [CNT_W-1:0] counts_num,
  output logic [2:0]       state_code,
  output logic [1:0]       clk_freq_sel,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             busy,
  output logic             wash_done
);

  typedef enum logic [2:0] {
    st_idle  = IDLE_CODE,
    st_fill  = FILL_CODE,
    st_wash  = WASH_CODE,
    st_rinse = RINSE_CODE,
    st_spin  = SPIN_CODE
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       freq_r, freq_s;
  logic             pass_r, pass_s;
  logic             dbl_r, dbl_s;
  logic             done_r, done_s;
  logic             busy_r;
  logic [CNT_W:0]   cnt_inc_s;
  logic             term_s;

  // One bit wider than the counter so an all-ones duration never wraps the compare.
  assign cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
  assign term_s    = (cnt_inc_s >= {1'b0, counts_num});

  // Next-state and next-register values for the phase sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    freq_s  = freq_r;
    pass_s  = pass_r;
    dbl_s   = dbl_r;
    done_s  = done_r;
    case (state_r)
      st_idle: begin
        if (coin_in) begin
          state_s = st_fill;
          freq_s  = clk_freq;
          dbl_s   = double_wash;
          pass_s  = 1'b0;
          cnt_s   = {CNT_W{1'b0}};
          done_s  = 1'b0;
        end else begin
          state_s = st_idle;
        end
      end
      st_fill: begin
        if (term_s) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = st_wash;
        end else begin
          cnt_s = cnt_inc_s[CNT_W-1:0];
        end
      end
      st_wash: begin
        if (term_s) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = st_rinse;
        end else begin
          cnt_s = cnt_inc_s[CNT_W-1:0];
        end
      end
      st_rinse: begin
        if (term_s) begin
          cnt_s = {CNT_W{1'b0}};
          // The second pass is taken at most once per accepted coin.
          if (dbl_r && !pass_r) begin
            state_s = st_wash;
            pass_s  = 1'b1;
          end else begin
            state_s = st_spin;
          end
        end else begin
          cnt_s = cnt_inc_s[CNT_W-1:0];
        end
      end
      st_spin: begin
        if (timer_pause) begin
          state_s = st_spin;
        end else if (term_s) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = st_idle;
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_inc_s[CNT_W-1:0];
        end
      end
      default: begin
        state_s = st_idle;
        cnt_s   = {CNT_W{1'b0}};
        pass_s  = 1'b0;
        dbl_s   = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= st_idle;
      cnt_r   <= {CNT_W{1'b0}};
      freq_r  <= 2'b00;
      pass_r  <= 1'b0;
      dbl_r   <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      freq_r  <= freq_s;
      pass_r  <= pass_s;
      dbl_r   <= dbl_s;
      done_r  <= done_s;
      busy_r  <= (state_s != st_idle);
    end
  end

  assign state_code   = state_r;
  assign clk_freq_sel = freq_r;
  assign phase_cnt    = cnt_r;
  assign busy         = busy_r;
  assign wash_done    = done_r;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Randomized self-checking bench for wash_cycle_sequencer with a phase-list reference model
// and a behavioural duration ROM (base duration plus the latched frequency select).
module tb_wash_cycle_sequencer;

  localparam logic [2:0] C_IDLE  = 3'b000;
  localparam logic [2:0] C_FILL  = 3'b001;
  localparam logic [2:0] C_WASH  = 3'b011;
  localparam logic [2:0] C_RINSE = 3'b111;
  localparam logic [2:0] C_SPIN  = 3'b110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coin_in = 1'b0;
  logic        double_wash = 1'b0;
  logic [1:0]  clk_freq = 2'b00;
  logic        timer_pause = 1'b0;
  logic [31:0] counts_num;
  logic [2:0]  state_code;
  logic [1:0]  clk_freq_sel;
  logic [31:0] phase_cnt;
  logic        busy;
  logic        wash_done;

  int          errors = 0;
  int          checks = 0;
  bit          fill_ovr_en = 1'b0;
  logic [31:0] fill_val = 32'd0;

  wash_cycle_sequencer dut (
    .clk(clk), .rst(rst), .coin_in(coin_in), .double_wash(double_wash),
    .clk_freq(clk_freq), .timer_pause(timer_pause), .counts_num(counts_num),
    .state_code(state_code), .clk_freq_sel(clk_freq_sel), .phase_cnt(phase_cnt),
    .busy(busy), .wash_done(wash_done)
  );

  always #5 clk = ~clk;

  // Phase-duration ROM: FILL=4, WASH=6, RINSE=3, SPIN=2 cycles, each stretched by clk_freq_sel.
  always_comb begin
    case (state_code)
      C_FILL:  counts_num = fill_ovr_en ? fill_val : 32'd4 + {30'd0, clk_freq_sel};
      C_WASH:  counts_num = 32'd6 + {30'd0, clk_freq_sel};
      C_RINSE: counts_num = 32'd3 + {30'd0, clk_freq_sel};
      C_SPIN:  counts_num = 32'd2 + {30'd0, clk_freq_sel};
      default: counts_num = 32'd0;
    endcase
  end

  function automatic int model_dur(logic [2:0] code, logic [1:0] f, bit ovr, logic [31:0] ov);
    int d;
    case (code)
      C_FILL:  d = ovr ? int'(ov) : 4 + int'(f);
      C_WASH:  d = 6 + int'(f);
      C_RINSE: d = 3 + int'(f);
      C_SPIN:  d = 2 + int'(f);
      default: d = 0;
    endcase
    return (d < 1) ? 1 : d;
  endfunction

  // Runs one accepted wash end to end, comparing every cycle against the phase-list model.
  task automatic run_wash(input bit dbl, input logic [1:0] f, input logic [2:0] pause_code,
                          input int pause_len, input bit rand_pause,
                          output int busy_seen, output int model_len);
    logic [2:0] phases[$];
    logic [2:0] exp_code;
    logic       exp_busy;
    int p, c, pause_left;
    bit trig, finished;
    phases = '{C_FILL, C_WASH, C_RINSE};
    if (dbl) begin
      phases.push_back(C_WASH);
      phases.push_back(C_RINSE);
    end
    phases.push_back(C_SPIN);
    p = 0; c = 0; pause_left = 0; trig = 1'b0; finished = 1'b0;
    busy_seen = 0; model_len = 0;
    coin_in = 1'b1; double_wash = dbl; clk_freq = f; timer_pause = 1'b0;
    for (int guard = 0; guard < 3000; guard++) begin
      @(posedge clk); #1;
      exp_code = (p < phases.size()) ? phases[p] : C_IDLE;
      exp_busy = (p < phases.size());
      checks++;
      if (state_code !== exp_code || phase_cnt !== 32'(c)) begin
        errors++;
        $display("FAIL phase: state=%b cnt=%0d, expected state=%b cnt=%0d", state_code, phase_cnt, exp_code, c);
      end
      checks++;
      if (busy !== exp_busy || wash_done !== !exp_busy) begin
        errors++;
        $display("FAIL flags: busy=%b done=%b, expected busy=%b done=%b", busy, wash_done, exp_busy, !exp_busy);
      end
      checks++;
      if (clk_freq_sel !== f) begin
        errors++;
        $display("FAIL freq_sel: got %b, expected %b", clk_freq_sel, f);
      end
      if (busy === 1'b1) busy_seen++;
      if (!exp_busy) begin
        finished = 1'b1;
        break;
      end
      model_len++;
      // Noise on the start inputs while busy must be ignored.
      coin_in     = 1'($urandom_range(0, 1));
      double_wash = 1'($urandom_range(0, 1));
      clk_freq    = 2'($urandom_range(0, 3));
      if (!trig && pause_len > 0 && phases[p] == pause_code && c == 0) begin
        trig = 1'b1;
        pause_left = pause_len;
      end
      if (pause_left > 0) begin
        timer_pause = 1'b1;
        pause_left--;
      end else if (rand_pause) begin
        timer_pause = 1'($urandom_range(0, 1));
      end else begin
        timer_pause = 1'b0;
      end
      if (!(phases[p] == C_SPIN && timer_pause)) begin
        if (c + 1 >= model_dur(phases[p], f, fill_ovr_en, fill_val)) begin
          p++;
          c = 0;
        end else begin
          c++;
        end
      end
    end
    coin_in = 1'b0; timer_pause = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL run_timeout: wash did not return to idle, state=%b", state_code);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state_code !== 3'b000 || phase_cnt !== 32'd0 || clk_freq_sel !== 2'b00 ||
        busy !== 1'b0 || wash_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%b cnt=%0d sel=%b busy=%b done=%b, expected all zero",
               state_code, phase_cnt, clk_freq_sel, busy, wash_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int b, m;
    run_wash(1'b0, 2'b00, C_IDLE, 0, 1'b0, b, m);
    checks++;
    if (b !== 15) begin
      errors++;
      $display("FAIL single_len: busy cycles %0d, expected 15", b);
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (wash_done !== 1'b1 || state_code !== C_IDLE) begin
        errors++;
        $display("FAIL done_hold: done=%b state=%b, expected 1/000", wash_done, state_code);
      end
    end
  endtask

  task automatic test_double();
    int b, m;
    run_wash(1'b1, 2'b00, C_IDLE, 0, 1'b0, b, m);
    checks++;
    if (b !== 24) begin
      errors++;
      $display("FAIL double_len: busy cycles %0d, expected 24", b);
    end
  endtask

  task automatic test_spin_pause();
    int b, m;
    run_wash(1'b0, 2'b00, C_SPIN, 5, 1'b0, b, m);
    checks++;
    if (b !== 20) begin
      errors++;
      $display("FAIL spin_pause_len: busy cycles %0d, expected 20", b);
    end
    run_wash(1'b0, 2'b00, C_WASH, 5, 1'b0, b, m);
    checks++;
    if (b !== 15) begin
      errors++;
      $display("FAIL wash_pause_len: busy cycles %0d, expected 15", b);
    end
  endtask

  task automatic test_latching();
    int b, m;
    run_wash(1'b0, 2'b10, C_IDLE, 0, 1'b0, b, m);
    checks++;
    if (b !== 23) begin
      errors++;
      $display("FAIL latch_len: busy cycles %0d, expected 23", b);
    end
  endtask

  task automatic test_reset_mid();
    int b, m;
    bit hit;
    hit = 1'b0;
    coin_in = 1'b1; double_wash = 1'b0; clk_freq = 2'b00;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      coin_in = 1'b0;
      if (state_code === C_WASH && phase_cnt === 32'd3) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach: WASH cnt=3 not seen, state=%b cnt=%0d", state_code, phase_cnt);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (state_code !== C_IDLE || phase_cnt !== 32'd0 || busy !== 1'b0 || wash_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: state=%b cnt=%0d busy=%b done=%b, expected 000/0/0/0",
               state_code, phase_cnt, busy, wash_done);
    end
    run_wash(1'b0, 2'b00, C_IDLE, 0, 1'b0, b, m);
    checks++;
    if (b !== 15) begin
      errors++;
      $display("FAIL reset_mid_rerun: busy cycles %0d, expected 15", b);
    end
  endtask

  task automatic test_random();
    int b, m;
    for (int k = 0; k < 8; k++) begin
      run_wash(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), C_IDLE, 0, 1'b1, b, m);
      checks++;
      if (b !== m) begin
        errors++;
        $display("FAIL random_len[%0d]: busy cycles %0d, expected %0d", k, b, m);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_boundary();
    int b, m;
    bit back;
    fill_ovr_en = 1'b1;
    fill_val = 32'd0;
    run_wash(1'b0, 2'b00, C_IDLE, 0, 1'b0, b, m);
    checks++;
    if (b !== 12) begin
      errors++;
      $display("FAIL fill_zero_len: busy cycles %0d, expected 12", b);
    end
    fill_val = 32'hFFFF_FFFF;
    coin_in = 1'b1; clk_freq = 2'b00; double_wash = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      coin_in = 1'b0;
      checks++;
      if (state_code !== C_FILL || phase_cnt !== 32'(i)) begin
        errors++;
        $display("FAIL fill_max: state=%b cnt=%0d, expected 001 cnt=%0d", state_code, phase_cnt, i);
      end
    end
    // Dropping the ROM value below the elapsed count must end the phase at once.
    fill_val = 32'd20;
    @(posedge clk); #1;
    checks++;
    if (state_code !== C_WASH || phase_cnt !== 32'd0) begin
      errors++;
      $display("FAIL fill_shrink: state=%b cnt=%0d, expected 011 cnt=0", state_code, phase_cnt);
    end
    fill_ovr_en = 1'b0;
    back = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) begin
        back = 1'b1;
        break;
      end
    end
    checks++;
    if (!back || wash_done !== 1'b1) begin
      errors++;
      $display("FAIL boundary_finish: idle=%b done=%b, expected 1/1", back, wash_done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_spin_pause();
    test_latching();
    test_reset_mid();
    test_random();
    test_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
